// File: rtl/pipe_cache_pkg.sv
// pipe_cache_pkg
// Shared definitions for the pipe_cache controller and its way storage.
// Holds the controller state enum, the fixed CPU word width and helper
// functions that derive the address field widths from the cache geometry.
// No ports (package).
package pipe_cache_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WTHRU = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Width of a pointer/selector over n items; never narrower than one bit
   // so that degenerate geometries (1 way, 1 word per line) still elaborate.
   function automatic int ptrBits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Byte offset inside a line: word select plus the two byte-lane bits.
   function automatic int offsetBits(input int lineWords);
      return $clog2(lineWords) + 2;
   endfunction

   function automatic int indexBits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int tagBits(input int addrW, input int lineWords, input int sets);
      return addrW - offsetBits(lineWords) - indexBits(sets);
   endfunction

endpackage

// File: rtl/pipe_cache_way.sv
// pipe_cache_way
// Storage for one way of the cache: a valid bit, a tag and a full line of
// data per set. Reads are combinational on idx_i; writes happen at the
// clock edge. Data words have individual write enables so that a refill
// writes the whole line while a store-through hit patches a single word.
// Ports:
//   clk, rstn     clock and asynchronous active-low reset (valid bits only)
//   idx_i         set index used for both the read and the write
//   valid_o       valid bit of the indexed set
//   tag_o         stored tag of the indexed set
//   line_o        stored line of the indexed set, word 0 in the LSBs
//   wordWe_i      per-word write enable for the indexed set
//   wrLine_i      write data laid out as a line (word w at bits [32w +: 32])
//   fill_i        install: write the tag and set the valid bit
//   wrTag_i       tag written on fill_i
//   clrAll_i      clear every valid bit in this way
module pipe_cache_way
   import pipe_cache_pkg::*;
#(
   parameter int TAG_W      = 24,
   parameter int IDX_W      = 4,
   parameter int LINE_WORDS = 4
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic [IDX_W-1:0]             idx_i,
   output logic                         valid_o,
   output logic [TAG_W-1:0]             tag_o,
   output logic [WORD_W*LINE_WORDS-1:0] line_o,
   input  logic [LINE_WORDS-1:0]        wordWe_i,
   input  logic [WORD_W*LINE_WORDS-1:0] wrLine_i,
   input  logic                         fill_i,
   input  logic [TAG_W-1:0]             wrTag_i,
   input  logic                         clrAll_i
);

   localparam int SETS = 1 << IDX_W;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tagMem  [SETS];
   logic [WORD_W-1:0] dataMem [SETS][LINE_WORDS];

   assign valid_o = valid_q[idx_i];
   assign tag_o   = tagMem[idx_i];

   // Assemble the indexed line from its words so the lookup is purely
   // combinational.
   always_comb begin
      line_o = '0;
      for (int w = 0; w < LINE_WORDS; w++) begin
         line_o[w*WORD_W +: WORD_W] = dataMem[idx_i][w];
      end
   end

   // Valid bits are the only state that must be reset; a flush clears them
   // all at once, an install sets the one for the indexed set.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid_q <= '0;
      end else if (clrAll_i) begin
         valid_q <= '0;
      end else if (fill_i) begin
         valid_q[idx_i] <= 1'b1;
      end
   end

   // Tag store; contents are meaningless until the valid bit is set.
   always_ff @(posedge clk) begin
      if (fill_i) begin
         tagMem[idx_i] <= wrTag_i;
      end
   end

   // Data store with per-word enables.
   always_ff @(posedge clk) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
         if (wordWe_i[w]) begin
            dataMem[idx_i][w] <= wrLine_i[w*WORD_W +: WORD_W];
         end
      end
   end

endmodule

// File: rtl/pipe_cache.sv
// pipe_cache
// Set-associative, write-through cache controller shared by the fetch and
// memory stages. Hits are answered combinationally in the request cycle.
// Read misses refill a whole line over a req/ack RAM handshake, stores are
// written through to RAM (updating the cached word on a hit, never
// allocating on a miss). Victims are chosen round-robin per set.
// Ports:
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   icpu_req       CPU access valid, held until a cycle with ocpu_miss=0
//   icpu_we        store when 1 (ignored when WRITE_EN=0)
//   icpu_addr      word-aligned byte address
//   icpu_wdata     store data
//   iflush         invalidate all lines
//   ocpu_rdata     read data (valid when icpu_req=1 and ocpu_miss=0)
//   ocpu_miss      pipeline stall request
//   oram_req       RAM request (registered)
//   oram_we        RAM write for store-through (registered)
//   oram_addr      line-aligned fill address or store word address
//   oram_wdata     store data to RAM
//   iram_ack       RAM done; iram_line valid in the same cycle
//   iram_line      refill line, word 0 in the LSBs
//   omiss_cnt      read-miss counter, wraps
module pipe_cache
   import pipe_cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int SETS       = 16,
   parameter int WAYS       = 2,
   parameter int WRITE_EN   = 1,
   parameter int COUNT_W    = 16
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         icpu_req,
   input  logic                         icpu_we,
   input  logic [ADDR_W-1:0]            icpu_addr,
   input  logic [WORD_W-1:0]            icpu_wdata,
   input  logic                         iflush,
   output logic [WORD_W-1:0]            ocpu_rdata,
   output logic                         ocpu_miss,
   output logic                         oram_req,
   output logic                         oram_we,
   output logic [ADDR_W-1:0]            oram_addr,
   output logic [WORD_W-1:0]            oram_wdata,
   input  logic                         iram_ack,
   input  logic [WORD_W*LINE_WORDS-1:0] iram_line,
   output logic [COUNT_W-1:0]           omiss_cnt
);

   localparam int OFF_W  = offsetBits(LINE_WORDS);
   localparam int IDX_W  = indexBits(SETS);
   localparam int TAG_W  = tagBits(ADDR_W, LINE_WORDS, SETS);
   localparam int WSEL_W = ptrBits(LINE_WORDS);
   localparam int VIC_W  = ptrBits(WAYS);
   localparam int LINE_W = WORD_W * LINE_WORDS;

   state_t              state_q;
   logic                ramReq_q;
   logic                ramWe_q;
   logic [ADDR_W-1:0]   ramAddr_q;
   logic [WORD_W-1:0]   ramWdata_q;
   logic [WORD_W-1:0]   doneData_q;
   logic                flushPend_q;
   logic [COUNT_W-1:0]  missCnt_q;
   logic [COUNT_W-1:0]  missCnt_d;
   logic [VIC_W-1:0]    victim_q [SETS];

   logic [TAG_W-1:0]    reqTag;
   logic [IDX_W-1:0]    reqIdx;
   logic [WSEL_W-1:0]   reqWord;
   logic [ADDR_W-1:0]   lineAddr;
   logic                isStore;
   logic [LINE_WORDS-1:0] wordOneHot;
   logic [VIC_W-1:0]    victimSel;

   logic                fillAck;
   logic                storeAck;
   logic                clrValid;

   logic [WAYS-1:0]       wayValid;
   logic [WAYS-1:0]       wayHit;
   logic [WAYS-1:0]       wayFill;
   logic [TAG_W-1:0]      wayTag    [WAYS];
   logic [LINE_W-1:0]     wayLine   [WAYS];
   logic [LINE_WORDS-1:0] wayWordWe [WAYS];
   logic [LINE_W-1:0]     wayWrLine [WAYS];

   logic                hitAny;
   logic [LINE_W-1:0]   hitLine;
   logic [WORD_W-1:0]   hitWord;
   logic [WORD_W-1:0]   fillWord;

   // Address split. The request is held stable for the whole transaction,
   // so the same decode serves the lookup, the refill and the store patch.
   assign reqTag     = icpu_addr[ADDR_W-1 -: TAG_W];
   assign reqIdx     = icpu_addr[OFF_W +: IDX_W];
   assign reqWord    = (LINE_WORDS > 1) ? icpu_addr[2 +: WSEL_W] : '0;
   assign lineAddr   = {icpu_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign isStore    = (WRITE_EN != 0) && icpu_we;
   assign wordOneHot = LINE_WORDS'(1) << reqWord;
   assign victimSel  = victim_q[reqIdx];

   assign fillAck  = (state_q == FILL)  && iram_ack;
   assign storeAck = (state_q == WTHRU) && iram_ack;

   // A flush seen while idle takes effect at once; one seen mid-transaction
   // is deferred until the DONE->IDLE edge so the fill still installs and
   // is then wiped along with everything else.
   assign clrValid = ((state_q == IDLE) && iflush) ||
                     ((state_q == DONE) && (flushPend_q || iflush));

   genvar g;
   generate
      for (g = 0; g < WAYS; g++) begin : gWay
         assign wayHit[g]    = wayValid[g] && (wayTag[g] == reqTag);
         assign wayFill[g]   = fillAck && (victimSel == VIC_W'(g));
         assign wayWordWe[g] = wayFill[g] ? '1 :
                               ((storeAck && wayHit[g]) ? wordOneHot : '0);
         assign wayWrLine[g] = wayFill[g] ? iram_line : {LINE_WORDS{icpu_wdata}};

         pipe_cache_way #(
            .TAG_W      (TAG_W),
            .IDX_W      (IDX_W),
            .LINE_WORDS (LINE_WORDS)
         ) uWay (
            .clk      (clk),
            .rstn     (rstn),
            .idx_i    (reqIdx),
            .valid_o  (wayValid[g]),
            .tag_o    (wayTag[g]),
            .line_o   (wayLine[g]),
            .wordWe_i (wayWordWe[g]),
            .wrLine_i (wayWrLine[g]),
            .fill_i   (wayFill[g]),
            .wrTag_i  (reqTag),
            .clrAll_i (clrValid)
         );
      end
   endgenerate

   // Merge the per-way hits; at most one way can match a given tag.
   always_comb begin
      hitAny  = 1'b0;
      hitLine = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (wayHit[w]) begin
            hitAny  = 1'b1;
            hitLine = wayLine[w];
         end
      end
   end

   assign hitWord   = hitLine[int'(reqWord)*WORD_W +: WORD_W];
   assign fillWord  = iram_line[int'(reqWord)*WORD_W +: WORD_W];
   assign missCnt_d = missCnt_q + COUNT_W'(1);

   // Controller FSM with registered RAM-side outputs. The RAM request,
   // address and data are loaded on entry to FILL/WTHRU and held until the
   // ack edge, so RAM sees stable values for the whole handshake.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         ramReq_q    <= 1'b0;
         ramWe_q     <= 1'b0;
         ramAddr_q   <= '0;
         ramWdata_q  <= '0;
         doneData_q  <= '0;
         flushPend_q <= 1'b0;
         missCnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (icpu_req) begin
                  if (isStore) begin
                     state_q    <= WTHRU;
                     ramReq_q   <= 1'b1;
                     ramWe_q    <= 1'b1;
                     ramAddr_q  <= icpu_addr;
                     ramWdata_q <= icpu_wdata;
                  end else if (!hitAny) begin
                     state_q    <= FILL;
                     ramReq_q   <= 1'b1;
                     ramWe_q    <= 1'b0;
                     ramAddr_q  <= lineAddr;
                     missCnt_q  <= missCnt_d;
                  end
               end
            end
            FILL: begin
               if (iflush) begin
                  flushPend_q <= 1'b1;
               end
               if (iram_ack) begin
                  state_q    <= DONE;
                  ramReq_q   <= 1'b0;
                  ramWe_q    <= 1'b0;
                  doneData_q <= fillWord;
               end
            end
            WTHRU: begin
               if (iflush) begin
                  flushPend_q <= 1'b1;
               end
               if (iram_ack) begin
                  state_q    <= DONE;
                  ramReq_q   <= 1'b0;
                  ramWe_q    <= 1'b0;
                  doneData_q <= '0;
               end
            end
            DONE: begin
               flushPend_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Round-robin victim pointers, one per set; they advance on each install
   // and deliberately survive a flush.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int s = 0; s < SETS; s++) begin
            victim_q[s] <= '0;
         end
      end else if (fillAck) begin
         if (WAYS > 1) begin
            victim_q[reqIdx] <= victimSel + VIC_W'(1);
         end else begin
            victim_q[reqIdx] <= '0;
         end
      end
   end

   // CPU-side responses. In IDLE the lookup result drives the stall and the
   // data combinationally; in DONE the word captured at the ack edge is
   // returned without another lookup.
   always_comb begin
      ocpu_miss  = 1'b0;
      ocpu_rdata = '0;
      case (state_q)
         IDLE: begin
            if (icpu_req) begin
               if (isStore || !hitAny) begin
                  ocpu_miss = 1'b1;
               end else begin
                  ocpu_rdata = hitWord;
               end
            end
         end
         FILL, WTHRU: begin
            ocpu_miss = icpu_req;
         end
         DONE: begin
            ocpu_rdata = doneData_q;
         end
         default: begin
            ocpu_miss = 1'b0;
         end
      endcase
   end

   assign oram_req   = ramReq_q;
   assign oram_we    = ramWe_q;
   assign oram_addr  = ramAddr_q;
   assign oram_wdata = ramWdata_q;
   assign omiss_cnt  = missCnt_q;

endmodule
